// File: rtl/alu_pkg.sv
// ALU op-code constants and issue-stage state encoding
// shared by the execute-stage issue logic.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_EQ  = 4'b1101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_st_e;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-to-ALU bundle seen by the issue register: decode offer,
// forwarding taps, and the ALU-side valid/ready outputs.
interface ex_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int RA   = 5
);
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [3:0]      id_ctrl;
    logic [4:0]      id_sa;
    logic [RA-1:0]   id_rs;
    logic [RA-1:0]   id_rt;
    logic [XLEN-1:0] id_rs_data;
    logic [XLEN-1:0] id_rt_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [RA-1:0]   id_rd;
    logic            id_wen;
    logic            exm_wen;
    logic [RA-1:0]   exm_rd;
    logic [XLEN-1:0] exm_data;
    logic            exm_data_ok;
    logic            wb_wen;
    logic [RA-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic            ex_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_x;
    logic [XLEN-1:0] alu_y;
    logic [4:0]      alu_sa;
    logic [RA-1:0]   ex_rd;
    logic            ex_wen;

    modport slave (
        input  flush, id_valid, id_ctrl, id_sa,
        input  id_rs, id_rt, id_rs_data, id_rt_data,
        input  id_imm, id_use_imm, id_rd, id_wen,
        input  exm_wen, exm_rd, exm_data, exm_data_ok,
        input  wb_wen, wb_rd, wb_data, ex_ready,
        output id_ready, ex_valid, alu_ctrl, alu_x,
        output alu_y, alu_sa, ex_rd, ex_wen
    );

    modport master (
        output flush, id_valid, id_ctrl, id_sa,
        output id_rs, id_rt, id_rs_data, id_rt_data,
        output id_imm, id_use_imm, id_rd, id_wen,
        output exm_wen, exm_rd, exm_data, exm_data_ok,
        output wb_wen, wb_rd, wb_data, ex_ready,
        input  id_ready, ex_valid, alu_ctrl, alu_x,
        input  alu_y, alu_sa, ex_rd, ex_wen
    );

endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Per-source operand forwarding: r0 is hardwired, EX/MEM beats
// MEM/WB, and an EX/MEM match without data raises a hazard.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic [RA-1:0]   addr_i,
    input  logic [XLEN-1:0] stored_i,
    input  logic            exm_wen_i,
    input  logic [RA-1:0]   exm_rd_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic            exm_ok_i,
    input  logic            wb_wen_i,
    input  logic [RA-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            hazard_o
);

    always_comb begin
        data_o   = stored_i;
        hazard_o = 1'b0;
        if (addr_i == '0) begin
            data_o = '0;
        end else if (exm_wen_i && exm_rd_i == addr_i) begin
            data_o   = exm_data_i;
            hazard_o = ~exm_ok_i;
        end else if (wb_wen_i && wb_rd_i == addr_i) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// Single-entry issue register in front of the ALU with operand
// forwarding, load-use stall and flush.
module ex_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_issue_stage_if.slave   bus
);

    issue_st_e       state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [4:0]      sa_q, sa_d;
    logic [RA-1:0]   rs_q, rs_d;
    logic [RA-1:0]   rt_q, rt_d;
    logic [XLEN-1:0] rs_data_q, rs_data_d;
    logic [XLEN-1:0] rt_data_q, rt_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            use_imm_q, use_imm_d;
    logic [RA-1:0]   rd_q, rd_d;
    logic            wen_q, wen_d;

    logic [XLEN-1:0] rs_val, rt_val;
    logic            hz_rs, hz_rt;
    logic            held, hazard;
    logic            ex_valid, fire;
    logic            id_ready, accept;

    fwd_mux #(.XLEN(XLEN), .RA(RA)) u_fwd_rs (
        .addr_i     (rs_q),
        .stored_i   (rs_data_q),
        .exm_wen_i  (bus.exm_wen),
        .exm_rd_i   (bus.exm_rd),
        .exm_data_i (bus.exm_data),
        .exm_ok_i   (bus.exm_data_ok),
        .wb_wen_i   (bus.wb_wen),
        .wb_rd_i    (bus.wb_rd),
        .wb_data_i  (bus.wb_data),
        .data_o     (rs_val),
        .hazard_o   (hz_rs)
    );

    fwd_mux #(.XLEN(XLEN), .RA(RA)) u_fwd_rt (
        .addr_i     (rt_q),
        .stored_i   (rt_data_q),
        .exm_wen_i  (bus.exm_wen),
        .exm_rd_i   (bus.exm_rd),
        .exm_data_i (bus.exm_data),
        .exm_ok_i   (bus.exm_data_ok),
        .wb_wen_i   (bus.wb_wen),
        .wb_rd_i    (bus.wb_rd),
        .wb_data_i  (bus.wb_data),
        .data_o     (rt_val),
        .hazard_o   (hz_rt)
    );

    function automatic logic wb_hit(
        input logic          wen,
        input logic [RA-1:0] wrd,
        input logic [RA-1:0] addr
    );
        return wen && (addr != '0) && (wrd == addr);
    endfunction

    assign held     = (state_q != ST_EMPTY);
    assign hazard   = hz_rs | (hz_rt & ~use_imm_q);
    assign ex_valid = held & ~hazard;
    assign fire     = ex_valid & bus.ex_ready;
    assign id_ready = ~held | fire;
    assign accept   = bus.id_valid & id_ready & ~bus.flush;

    assign bus.ex_valid = ex_valid;
    assign bus.id_ready = id_ready;
    assign bus.alu_ctrl = ctrl_q;
    assign bus.alu_sa   = sa_q;
    assign bus.alu_x    = rs_val;
    assign bus.alu_y    = use_imm_q ? imm_q : rt_val;
    assign bus.ex_rd    = rd_q;
    assign bus.ex_wen   = wen_q;

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        sa_d      = sa_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        // a stalled entry absorbs write-back so the value outlives its writer
        if (held && !fire) begin
            state_d = hazard ? ST_WAIT : ST_ISSUE;
            if (wb_hit(bus.wb_wen, bus.wb_rd, rs_q))
                rs_data_d = bus.wb_data;
            if (wb_hit(bus.wb_wen, bus.wb_rd, rt_q))
                rt_data_d = bus.wb_data;
        end else if (fire) begin
            state_d = ST_EMPTY;
        end
        if (accept) begin
            state_d   = ST_ISSUE;
            ctrl_d    = bus.id_ctrl;
            sa_d      = bus.id_sa;
            rs_d      = bus.id_rs;
            rt_d      = bus.id_rt;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
            imm_d     = bus.id_imm;
            use_imm_d = bus.id_use_imm;
            rd_d      = bus.id_rd;
            wen_d     = bus.id_wen;
            if (wb_hit(bus.wb_wen, bus.wb_rd, bus.id_rs))
                rs_data_d = bus.wb_data;
            if (wb_hit(bus.wb_wen, bus.wb_rd, bus.id_rt))
                rt_data_d = bus.wb_data;
        end
        if (bus.flush)
            state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            ctrl_q    <= '0;
            sa_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            sa_q      <= sa_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
        end
    end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for the issue register: reset, forwarding,
// load-use stall, immediate bypass, held write-back and flush.
module tb_ex_issue_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_issue_stage_if #(.XLEN(32), .RA(5)) bus ();

    ex_issue_stage #(.XLEN(32), .RA(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic ui, input logic [31:0] imm,
                         input logic [3:0] ctrl, input logic [4:0] rd);
        bus.id_valid   = 1'b1;
        bus.id_rs      = rs;
        bus.id_rs_data = rsd;
        bus.id_rt      = rt;
        bus.id_rt_data = rtd;
        bus.id_use_imm = ui;
        bus.id_imm     = imm;
        bus.id_ctrl    = ctrl;
        bus.id_sa      = 5'd3;
        bus.id_rd      = rd;
        bus.id_wen     = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flush = 0; bus.id_valid = 0; bus.id_ctrl = 0; bus.id_sa = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
        bus.id_imm = 0; bus.id_use_imm = 0; bus.id_rd = 0; bus.id_wen = 0;
        bus.exm_wen = 0; bus.exm_rd = 0; bus.exm_data = 0; bus.exm_data_ok = 1;
        bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 1;
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ready", 32'(bus.id_ready), 32'd1);
        chk("rst_x", bus.alu_x, 32'd0);
        chk("rst_y", bus.alu_y, 32'd0);
        chk("rst_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_sa", 32'(bus.alu_sa), 32'd0);
        chk("rst_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_wen", 32'(bus.ex_wen), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // plain add, no forwarding
        offer(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, ALU_ADD, 5'd8);
        #1 chk("t1_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t1_valid", 32'(bus.ex_valid), 32'd1);
        chk("t1_x", bus.alu_x, 32'd5);
        chk("t1_y", bus.alu_y, 32'd7);
        chk("t1_ctrl", 32'(bus.alu_ctrl), 32'(ALU_ADD));
        chk("t1_rd", 32'(bus.ex_rd), 32'd8);
        chk("t1_sa", 32'(bus.alu_sa), 32'd3);
        tick();
        chk("t1_drain", 32'(bus.ex_valid), 32'd0);

        // EX/MEM beats MEM/WB; rt = r0 reads zero
        offer(5'd3, 32'd1, 5'd0, 32'h77, 1'b0, 32'd0, ALU_SUB, 5'd9);
        tick();
        bus.id_valid = 1'b0;
        bus.exm_wen = 1; bus.exm_rd = 3; bus.exm_data = 32'h10;
        bus.wb_wen = 1; bus.wb_rd = 3; bus.wb_data = 32'h20;
        #1;
        chk("t2_x", bus.alu_x, 32'h10);
        chk("t2_y_r0", bus.alu_y, 32'd0);
        chk("t2_ctrl", 32'(bus.alu_ctrl), 32'(ALU_SUB));
        tick();
        bus.exm_rd = 0; bus.wb_rd = 0;
        offer(5'd0, 32'h33, 5'd2, 32'd4, 1'b0, 32'd0, ALU_OR, 5'd9);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t2_r0_valid", 32'(bus.ex_valid), 32'd1);
        chk("t2_r0_x", bus.alu_x, 32'd0);
        tick();
        bus.exm_wen = 0; bus.wb_wen = 0;

        // load-use stall on rt
        offer(5'd1, 32'd2, 5'd4, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd10);
        bus.exm_wen = 1; bus.exm_rd = 4; bus.exm_data_ok = 0;
        bus.exm_data = 32'hDEAD;
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t3_stall1_valid", 32'(bus.ex_valid), 32'd0);
        chk("t3_stall1_ready", 32'(bus.id_ready), 32'd0);
        tick();
        chk("t3_stall2_valid", 32'(bus.ex_valid), 32'd0);
        chk("t3_stall2_ready", 32'(bus.id_ready), 32'd0);
        tick();
        bus.exm_data_ok = 1; bus.exm_data = 32'h99;
        #1;
        chk("t3_go_valid", 32'(bus.ex_valid), 32'd1);
        chk("t3_go_y", bus.alu_y, 32'h99);
        chk("t3_go_x", bus.alu_x, 32'd2);
        chk("t3_go_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk("t3_drain", 32'(bus.ex_valid), 32'd0);

        // same hazard is ignored when y is the immediate
        bus.exm_data_ok = 0;
        offer(5'd1, 32'd3, 5'd4, 32'd0, 1'b1, 32'hFFFF_FFFC, ALU_SLT, 5'd11);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t4_valid", 32'(bus.ex_valid), 32'd1);
        chk("t4_y", bus.alu_y, 32'hFFFF_FFFC);
        chk("t4_x", bus.alu_x, 32'd3);
        tick();
        bus.exm_wen = 0; bus.exm_data_ok = 1;

        // held entry captures write-back while ALU is busy
        bus.ex_ready = 0;
        offer(5'd6, 32'h11, 5'd0, 32'd0, 1'b0, 32'd0, ALU_XOR, 5'd12);
        tick();
        bus.id_valid = 1'b0;
        bus.wb_wen = 1; bus.wb_rd = 6; bus.wb_data = 32'h55;
        #1;
        chk("t5_c1_x", bus.alu_x, 32'h55);
        chk("t5_c1_ready", 32'(bus.id_ready), 32'd0);
        tick();
        bus.wb_wen = 0;
        #1;
        chk("t5_c2_x", bus.alu_x, 32'h55);
        tick();
        chk("t5_c3_x", bus.alu_x, 32'h55);
        chk("t5_c3_valid", 32'(bus.ex_valid), 32'd1);
        chk("t5_c3_rd", 32'(bus.ex_rd), 32'd12);
        bus.ex_ready = 1;
        #1;
        chk("t5_fire_x", bus.alu_x, 32'h55);
        tick();

        // stream of four, flush as the third is offered
        offer(5'd1, 32'h100, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd1);
        tick();
        offer(5'd1, 32'h200, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd2);
        #1;
        chk("t6_i1_x", bus.alu_x, 32'h100);
        chk("t6_i1_ready", 32'(bus.id_ready), 32'd1);
        tick();
        offer(5'd1, 32'h300, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd3);
        bus.flush = 1'b1;
        #1;
        chk("t6_i2_valid", 32'(bus.ex_valid), 32'd1);
        chk("t6_i2_x", bus.alu_x, 32'h200);
        tick();
        bus.flush = 1'b0;
        offer(5'd1, 32'h400, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd4);
        #1;
        chk("t6_i3_gone", 32'(bus.ex_valid), 32'd0);
        chk("t6_i4_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t6_i4_valid", 32'(bus.ex_valid), 32'd1);
        chk("t6_i4_x", bus.alu_x, 32'h400);
        chk("t6_i4_rd", 32'(bus.ex_rd), 32'd4);
        tick();
        chk("t6_drain", 32'(bus.ex_valid), 32'd0);

        // reset drops a held entry at once
        bus.ex_ready = 0;
        offer(5'd1, 32'h44, 5'd0, 32'd0, 1'b0, 32'd0, ALU_AND, 5'd9);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("t7_held", 32'(bus.ex_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("t7_rst_ready", 32'(bus.id_ready), 32'd1);
        chk("t7_rst_x", bus.alu_x, 32'd0);
        chk("t7_rst_rd", 32'(bus.ex_rd), 32'd0);
        chk("t7_rst_wen", 32'(bus.ex_wen), 32'd0);
        chk("t7_rst_ctrl", 32'(bus.alu_ctrl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
